// File: rtl/boot_loader.sv
// Boot loader: validates a ROM header, programs the RAM clock registers, then
// replays (address, data) pairs from boot ROM as single AXI writes.
module boot_loader #(
    parameter int unsigned ROM_ADDR_W     = 12,
    parameter logic [63:0] FREQ_REG_ADDR  = 64'h10000600,
    parameter logic [63:0] FREQ_VALUE     = 64'd3200,
    parameter logic [63:0] CLKEN_REG_ADDR = 64'h10000E18,
    parameter logic [31:0] MAGIC          = 32'hB0071DEA
) (
    input  logic                  clk_i,
    input  logic                  arst_ni,
    input  logic                  start_i,
    output logic                  rom_en_o,
    output logic [ROM_ADDR_W-1:0] rom_addr_o,
    input  logic [63:0]           rom_data_i,
    output logic                  aw_valid_o,
    output logic [63:0]           aw_addr_o,
    input  logic                  aw_ready_i,
    output logic                  w_valid_o,
    output logic [63:0]           w_data_o,
    output logic [7:0]            w_strb_o,
    input  logic                  w_ready_i,
    input  logic                  b_valid_i,
    input  logic [1:0]            b_resp_i,
    output logic                  b_ready_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [15:0]           err_cnt_o
);
    localparam int unsigned CNT_W = 16;
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] HDR     = 3'd1;
    localparam logic [2:0] CFG     = 3'd2;
    localparam logic [2:0] FETCH_A = 3'd3;
    localparam logic [2:0] FETCH_D = 3'd4;
    localparam logic [2:0] SEND    = 3'd5;
    localparam logic [2:0] WAIT_B  = 3'd6;
    localparam logic [2:0] DONE    = 3'd7;
    localparam logic [1:0] CFG_FREQ  = 2'd0;
    localparam logic [1:0] CFG_CLKEN = 2'd1;
    localparam logic [1:0] CFG_PAIRS = 2'd2;

    logic [2:0]            state_q, state_d;
    logic                  phase_q, phase_d;
    logic                  rom_en_q, rom_en_d;
    logic [ROM_ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [ROM_ADDR_W-1:0] left_q, left_d;
    logic                  aw_valid_q, aw_valid_d;
    logic [63:0]           aw_addr_q, aw_addr_d;
    logic                  w_valid_q, w_valid_d;
    logic [63:0]           w_data_q, w_data_d;
    logic [7:0]            w_strb_q, w_strb_d;
    logic                  b_ready_q, b_ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      err_cnt_q, err_cnt_d;
    logic [1:0]            cfg_sel_q, cfg_sel_d;
    logic [63:0]           pair_addr_q, pair_addr_d;

    logic        err_ev;
    logic        go_next;
    logic        aw_ok;
    logic        w_ok;
    logic [33:0] hdr_need;
    logic        hdr_bad;

    // Header needs words 0..2N inside the ROM; 34 bits keeps 2N+1 from wrapping.
    assign hdr_need = {1'b0, rom_data_i[31:0], 1'b1};
    assign hdr_bad  = (rom_data_i[63:32] != MAGIC) || (hdr_need > (34'd1 << ROM_ADDR_W));
    assign aw_ok    = !aw_valid_q || aw_ready_i;
    assign w_ok     = !w_valid_q || w_ready_i;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        rom_en_d    = rom_en_q;
        rom_addr_d  = rom_addr_q;
        left_d      = left_q;
        aw_valid_d  = aw_valid_q;
        aw_addr_d   = aw_addr_q;
        w_valid_d   = w_valid_q;
        w_data_d    = w_data_q;
        b_ready_d   = b_ready_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;
        err_cnt_d   = err_cnt_q;
        cfg_sel_d   = cfg_sel_q;
        pair_addr_d = pair_addr_q;
        err_ev      = 1'b0;
        go_next     = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d    = HDR;
                    phase_d    = 1'b0;
                    rom_en_d   = 1'b1;
                    rom_addr_d = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    err_cnt_d  = '0;
                end
            end
            HDR: begin
                if (!phase_q) begin
                    rom_en_d = 1'b0;
                    phase_d  = 1'b1;
                end else if (hdr_bad) begin
                    err_ev  = 1'b1;
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    left_d    = ROM_ADDR_W'(rom_data_i[31:0]);
                    cfg_sel_d = CFG_FREQ;
                    state_d   = CFG;
                end
            end
            CFG: begin
                aw_addr_d  = (cfg_sel_q == CFG_FREQ) ? FREQ_REG_ADDR : CLKEN_REG_ADDR;
                w_data_d   = (cfg_sel_q == CFG_FREQ) ? FREQ_VALUE : 64'd1;
                aw_valid_d = 1'b1;
                w_valid_d  = 1'b1;
                state_d    = SEND;
            end
            FETCH_A: begin
                if (!phase_q) begin
                    rom_en_d = 1'b0;
                    phase_d  = 1'b1;
                end else begin
                    pair_addr_d = rom_data_i;
                    left_d      = left_q - ROM_ADDR_W'(1);
                    rom_en_d    = 1'b1;
                    rom_addr_d  = rom_addr_q + ROM_ADDR_W'(1);
                    phase_d     = 1'b0;
                    state_d     = FETCH_D;
                end
            end
            FETCH_D: begin
                if (!phase_q) begin
                    rom_en_d = 1'b0;
                    phase_d  = 1'b1;
                end else if (pair_addr_q[2:0] != 3'd0) begin
                    err_ev  = 1'b1;
                    go_next = 1'b1;
                end else begin
                    aw_addr_d  = pair_addr_q;
                    w_data_d   = rom_data_i;
                    aw_valid_d = 1'b1;
                    w_valid_d  = 1'b1;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (aw_valid_q && aw_ready_i) aw_valid_d = 1'b0;
                if (w_valid_q && w_ready_i) w_valid_d = 1'b0;
                if (aw_ok && w_ok) begin
                    state_d   = WAIT_B;
                    b_ready_d = 1'b1;
                end
            end
            WAIT_B: begin
                if (b_valid_i) begin
                    b_ready_d = 1'b0;
                    if (b_resp_i != 2'b00) err_ev = 1'b1;
                    if (cfg_sel_q == CFG_FREQ) begin
                        cfg_sel_d = CFG_CLKEN;
                        state_d   = CFG;
                    end else begin
                        cfg_sel_d = CFG_PAIRS;
                        go_next   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Either fetch the next pair's address word or finish the boot.
        if (go_next) begin
            if (left_q != '0) begin
                state_d    = FETCH_A;
                phase_d    = 1'b0;
                rom_en_d   = 1'b1;
                rom_addr_d = rom_addr_q + ROM_ADDR_W'(1);
            end else begin
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
        end

        if (err_ev) begin
            err_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
        end

        w_strb_d = {8{w_valid_d}};
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q     <= IDLE;
            phase_q     <= 1'b0;
            rom_en_q    <= 1'b0;
            rom_addr_q  <= '0;
            left_q      <= '0;
            aw_valid_q  <= 1'b0;
            aw_addr_q   <= '0;
            w_valid_q   <= 1'b0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            b_ready_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
            cfg_sel_q   <= CFG_FREQ;
            pair_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            rom_en_q    <= rom_en_d;
            rom_addr_q  <= rom_addr_d;
            left_q      <= left_d;
            aw_valid_q  <= aw_valid_d;
            aw_addr_q   <= aw_addr_d;
            w_valid_q   <= w_valid_d;
            w_data_q    <= w_data_d;
            w_strb_q    <= w_strb_d;
            b_ready_q   <= b_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
            cfg_sel_q   <= cfg_sel_d;
            pair_addr_q <= pair_addr_d;
        end
    end

    assign rom_en_o   = rom_en_q;
    assign rom_addr_o = rom_addr_q;
    assign aw_valid_o = aw_valid_q;
    assign aw_addr_o  = aw_addr_q;
    assign w_valid_o  = w_valid_q;
    assign w_data_o   = w_data_q;
    assign w_strb_o   = w_strb_q;
    assign b_ready_o  = b_ready_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign err_cnt_o  = err_cnt_q;
endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: ROM model, AXI write slave with programmable ready
// delays and error responses, and a boot-image reference model.
module tb_boot_loader;
    localparam logic [31:0] MAGIC = 32'hB0071DEA;

    typedef struct {
        logic [31:0]      tag;
        logic [31:0]      n;
        logic [2:0][63:0] a;
        logic [2:0][63:0] d;
        int               aw_dly;
        int               w_dly;
        int               bad_b;
        int               exp_wr;
        int               exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        arst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic        rom_en_o;
    logic [11:0] rom_addr_o;
    logic [63:0] rom_data_i = '0;
    logic        aw_valid_o;
    logic [63:0] aw_addr_o;
    logic        aw_ready_i = 1'b0;
    logic        w_valid_o;
    logic [63:0] w_data_o;
    logic [7:0]  w_strb_o;
    logic        w_ready_i = 1'b0;
    logic        b_valid_i = 1'b0;
    logic [1:0]  b_resp_i = 2'b00;
    logic        b_ready_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [15:0] err_cnt_o;

    boot_loader dut (
        .clk_i(clk), .arst_ni(arst_ni), .start_i(start_i),
        .rom_en_o(rom_en_o), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
        .aw_valid_o(aw_valid_o), .aw_addr_o(aw_addr_o), .aw_ready_i(aw_ready_i),
        .w_valid_o(w_valid_o), .w_data_o(w_data_o), .w_strb_o(w_strb_o), .w_ready_i(w_ready_i),
        .b_valid_i(b_valid_i), .b_resp_i(b_resp_i), .b_ready_o(b_ready_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk = ~clk;

    logic [63:0] rom [0:4095];
    always @(posedge clk) if (rom_en_o) rom_data_i <= rom[rom_addr_o];

    int          n_vec = 0;
    int          n_bad = 0;
    int          aw_dly = 0;
    int          w_dly = 0;
    int          bad_b_abs = -1;
    int          mon_bad = 0;
    int          b_sent = 0;
    logic [63:0] obs_a[$];
    logic [63:0] obs_d[$];
    logic [63:0] exp_a[$];
    logic [63:0] exp_d[$];
    vec_t        tbl[11];

    // AXI slave and protocol monitor, evaluated away from the active edge.
    int          aw_cnt, w_cnt;
    logic        aw_hs, w_hs, aw_pend, w_pend, aw_prev, w_prev, en_prev;
    logic [63:0] aw_hold, w_hold;
    always @(negedge clk or negedge arst_ni) begin
        if (!arst_ni) begin
            aw_ready_i = 1'b0; w_ready_i = 1'b0; b_valid_i = 1'b0; b_resp_i = 2'b00;
            aw_cnt = 0; w_cnt = 0; aw_hs = 1'b0; w_hs = 1'b0; aw_pend = 1'b0; w_pend = 1'b0;
            aw_prev = 1'b0; w_prev = 1'b0; en_prev = 1'b0; aw_hold = '0; w_hold = '0;
            obs_a.delete(); obs_d.delete(); b_sent = 0;
        end else begin
            if (aw_hs && aw_valid_o) mon_bad++;
            if (w_hs && w_valid_o) mon_bad++;
            if (aw_pend && aw_valid_o && aw_addr_o != aw_hold) mon_bad++;
            if (w_pend && w_valid_o && w_data_o != w_hold) mon_bad++;
            if ((aw_valid_o && !aw_prev) != (w_valid_o && !w_prev)) mon_bad++;
            if (w_valid_o && w_strb_o != 8'hFF) mon_bad++;
            if (rom_en_o && en_prev) mon_bad++;
            if (b_ready_o && !(b_sent < obs_a.size() && b_sent < obs_d.size())) mon_bad++;
            aw_ready_i = aw_valid_o && (aw_cnt >= aw_dly);
            w_ready_i  = w_valid_o && (w_cnt >= w_dly);
            aw_cnt = aw_valid_o ? aw_cnt + 1 : 0;
            w_cnt  = w_valid_o ? w_cnt + 1 : 0;
            aw_hs = aw_valid_o && aw_ready_i;
            w_hs  = w_valid_o && w_ready_i;
            if (aw_hs) obs_a.push_back(aw_addr_o);
            if (w_hs) obs_d.push_back(w_data_o);
            aw_pend = aw_valid_o && !aw_hs; aw_hold = aw_addr_o;
            w_pend  = w_valid_o && !w_hs;   w_hold  = w_data_o;
            aw_prev = aw_valid_o; w_prev = w_valid_o; en_prev = rom_en_o;
            if (b_valid_i) begin
                b_valid_i = 1'b0; b_resp_i = 2'b00; b_sent++;
            end else if (b_ready_o && b_sent < obs_a.size() && b_sent < obs_d.size()) begin
                b_valid_i = 1'b1;
                b_resp_i  = (b_sent == bad_b_abs) ? 2'd2 : 2'd0;
            end
            if (obs_a.size() > b_sent + 1) mon_bad++;
        end
    end

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic vec_t mk(logic [31:0] tag, logic [31:0] n, logic [63:0] a0, logic [63:0] d0,
                                logic [63:0] a1, logic [63:0] d1, int awd, int wd, int bb,
                                int ewr, int eerr);
        vec_t v;
        v.tag = tag; v.n = n;
        v.a[0] = a0; v.d[0] = d0; v.a[1] = a1; v.d[1] = d1; v.a[2] = '0; v.d[2] = '0;
        v.aw_dly = awd; v.w_dly = wd; v.bad_b = bb; v.exp_wr = ewr; v.exp_err = eerr;
        return v;
    endfunction

    // Reference: the list of writes a boot image should produce and its error total.
    task automatic model(input vec_t v, output int errs);
        exp_a.delete(); exp_d.delete(); errs = 0;
        if (v.tag != MAGIC || 2 * longint'(v.n) + 1 > 4096) errs = 1;
        else begin
            exp_a.push_back(64'h10000600); exp_d.push_back(64'd3200);
            exp_a.push_back(64'h10000E18); exp_d.push_back(64'd1);
            for (int k = 0; k < int'(v.n); k++) begin
                if (v.a[k][2:0] != 3'd0) errs++;
                else begin exp_a.push_back(v.a[k]); exp_d.push_back(v.d[k]); end
            end
            if (v.bad_b >= 0 && v.bad_b < exp_a.size()) errs++;
        end
    endtask

    task automatic load_rom(input vec_t v);
        rom[0] = {v.tag, v.n};
        for (int k = 0; k < 3; k++) begin
            rom[2 * k + 1] = v.a[k];
            rom[2 * k + 2] = v.d[k];
        end
        aw_dly = v.aw_dly; w_dly = v.w_dly;
    endtask

    task automatic pulse_start();
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
    endtask

    task automatic chk_zero(string name);
        chk({name, "_addr"}, aw_addr_o, 64'd0);
        chk({name, "_data"}, w_data_o, 64'd0);
        chk({name, "_ctl"}, 64'({rom_en_o, aw_valid_o, w_valid_o, b_ready_o, busy_o, done_o,
                                 err_o, w_strb_o, err_cnt_o, rom_addr_o}), 64'd0);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int errs, base, mbase, got, cyc;
        load_rom(v);
        model(v, errs);
        base = obs_a.size(); mbase = mon_bad;
        bad_b_abs = (v.bad_b < 0) ? -1 : base + v.bad_b;
        pulse_start();
        chk({name, "_started"}, 64'({busy_o, done_o, err_o}), 64'b100);
        cyc = 0;
        while (!done_o && cyc < 3000) begin @(negedge clk); cyc++; end
        chk({name, "_timeout"}, 64'(done_o), 64'd1);
        repeat (2) @(negedge clk);
        got = obs_a.size() - base;
        chk({name, "_nwr"}, 64'(got), 64'(v.exp_wr));
        chk({name, "_ndata"}, 64'(obs_d.size() - base), 64'(v.exp_wr));
        for (int i = 0; i < exp_a.size() && i < got; i++) begin
            chk($sformatf("%s_wa%0d", name, i), obs_a[base + i], exp_a[i]);
            chk($sformatf("%s_wd%0d", name, i), obs_d[base + i], exp_d[i]);
        end
        chk({name, "_errcnt"}, 64'(err_cnt_o), 64'(v.exp_err));
        chk({name, "_err"}, 64'(err_o), 64'(v.exp_err != 0));
        chk({name, "_end"}, 64'({done_o, busy_o, b_ready_o}), 64'b100);
        chk({name, "_proto"}, 64'(mon_bad - mbase), 64'd0);
    endtask

    initial begin
        int errs, cyc;
        vec_t v;
        tbl[0]  = mk(MAGIC, 2, 64'h80000000, 64'h1122334455667788, 64'h80000008, 64'hA5, 0, 0, -1, 4, 0);
        tbl[1]  = mk(32'hDEADBEEF, 2, 64'h80000000, 64'h1, 64'h80000008, 64'h2, 0, 0, -1, 0, 1);
        tbl[2]  = mk(MAGIC, 1, 64'h80000004, 64'h55, 64'h0, 64'h0, 0, 0, -1, 2, 1);
        tbl[3]  = mk(MAGIC, 1, 64'h80000010, 64'hCAFE, 64'h0, 64'h0, 3, 0, -1, 3, 0);
        tbl[4]  = mk(MAGIC, 1, 64'h80000018, 64'h77, 64'h0, 64'h0, 0, 0, 1, 3, 1);
        tbl[5]  = mk(MAGIC, 0, 64'h80000000, 64'h1, 64'h0, 64'h0, 0, 0, -1, 2, 0);
        tbl[6]  = mk(MAGIC, 2048, 64'h80000000, 64'h1, 64'h0, 64'h0, 0, 0, -1, 0, 1);
        tbl[7]  = mk(MAGIC, 32'hFFFFFFFF, 64'h80000000, 64'h1, 64'h0, 64'h0, 0, 0, -1, 0, 1);
        tbl[8]  = mk(MAGIC, 2, 64'h80000020, 64'h1, 64'h80000028, 64'h2, 0, 2, -1, 4, 0);
        tbl[9]  = mk(MAGIC, 2, 64'h80000001, 64'h3, 64'h80000040, 64'h9, 0, 0, 2, 3, 2);
        tbl[10] = mk(MAGIC, 1, 64'h80000048, 64'h3, 64'h0, 64'h0, 1, 2, 0, 3, 1);

        #3 chk_zero("reset");
        @(negedge clk); arst_ni = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_quiet", 64'({aw_valid_o, w_valid_o, rom_en_o, busy_o}), 64'd0);

        for (int i = 0; i < 11; i++) run_vec(tbl[i], $sformatf("t%0d", i));

        for (int r = 0; r < 16; r++) begin
            v.tag = ($urandom_range(0, 7) == 0) ? 32'($urandom) : MAGIC;
            v.n = 32'($urandom_range(0, 3));
            for (int k = 0; k < 3; k++) begin
                v.a[k] = 64'h80000000 + 64'($urandom_range(0, 255)) * 64'd8;
                if ($urandom_range(0, 3) == 0) v.a[k][2:0] = 3'($urandom_range(1, 7));
                v.d[k] = {32'($urandom), 32'($urandom)};
            end
            v.aw_dly = $urandom_range(0, 3); v.w_dly = $urandom_range(0, 3);
            v.bad_b = int'($urandom_range(0, 6)) - 1;
            model(v, errs);
            v.exp_wr = exp_a.size(); v.exp_err = errs;
            run_vec(v, $sformatf("r%0d", r));
        end

        // Reset in the middle of a write, then a full reboot.
        load_rom(tbl[0]);
        pulse_start();
        cyc = 0;
        while (!aw_valid_o && cyc < 200) begin @(negedge clk); cyc++; end
        chk("v6_reach_send", 64'(aw_valid_o), 64'd1);
        #2 arst_ni = 1'b0;
        #1 chk_zero("v6_async");
        repeat (2) @(negedge clk);
        arst_ni = 1'b1;
        repeat (4) @(negedge clk);
        chk("v6_quiet", 64'({aw_valid_o, w_valid_o, busy_o}), 64'd0);
        run_vec(tbl[0], "v6_rerun");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- ROM_ADDR_W, 12, boot ROM word-address width.
- FREQ_REG_ADDR, 64'h10000600, RAM clock-frequency register address.
- FREQ_VALUE, 64'd3200, value written to FREQ_REG_ADDR.
- CLKEN_REG_ADDR, 64'h10000E18, RAM clock-enable register address.
- MAGIC, 32'hB0071DEA, required header tag.

REQ-002 SHALL have ports (name, direction, width, meaning):
- clk_i, in, 1, sole clock.
- arst_ni, in, 1, asynchronous active-low reset.
- start_i, in, 1, begin boot.
- rom_en_o, in/out: out, 1, ROM read strobe.
- rom_addr_o, out, ROM_ADDR_W, ROM word address.
- rom_data_i, in, 64, ROM data, valid 1 cycle after rom_en_o.
- aw_valid_o, out, 1, AXI write-address valid.
- aw_addr_o, out, 64, AXI write address.
- aw_ready_i, in, 1, AXI write-address ready.
- w_valid_o, out, 1, AXI write-data valid.
- w_data_o, out, 64, AXI write data.
- w_strb_o, out, 8, AXI write strobe.
- w_ready_i, in, 1, AXI write-data ready.
- b_valid_i, in, 1, AXI write-response valid.
- b_resp_i, in, 2, AXI write-response code.
- b_ready_o, out, 1, AXI write-response ready.
- busy_o, out, 1, boot in progress.
- done_o, out, 1, boot finished.
- err_o, out, 1, sticky error flag.
- err_cnt_o, out, 16, error count.

REQ-003 SHALL use one clock, clk_i; reset arst_ni SHALL be asynchronous and active-low.

Function
REQ-004 SHALL be a state machine with states IDLE, HDR, CFG, FETCH_A, FETCH_D, SEND, WAIT_B, DONE.
REQ-005 SHALL, in IDLE or DONE, on start_i=1: clear err_o, err_cnt_o and done_o, set rom_addr_o=0, and go to HDR; start_i SHALL be ignored in all other states.
REQ-006 SHALL perform each ROM fetch in 2 cycles: cycle 1 drives rom_en_o=1 with the address; cycle 2 captures rom_data_i.
REQ-007 SHALL decode the header at ROM word 0: [63:32]=tag, [31:0]=pair count N.
REQ-008 SHALL treat the header as bad when tag!=MAGIC or 2N+1 > 2^ROM_ADDR_W; on a bad header it SHALL set err_o, increment err_cnt_o, and go to DONE with no AXI writes.
REQ-009 SHALL, on a good header, go to CFG and issue two writes in order: FREQ_VALUE to FREQ_REG_ADDR, then 64'd1 to CLKEN_REG_ADDR.
REQ-010 SHALL, for pair k (k=0..N-1), fetch the address from word 2k+1 (FETCH_A) and the data from word 2k+2 (FETCH_D), then write the data to that address.
REQ-011 SHALL, when N=0, go from CFG to DONE after the two config writes.
REQ-012 SHALL handle a pair address with [2:0]!=0 as follows: skip the write, set err_o, increment err_cnt_o, and continue with the next pair.
REQ-013 SHALL, in SEND, assert aw_valid_o and w_valid_o in the same cycle, with w_strb_o=8'hFF.
REQ-014 SHALL hold aw_addr_o and w_data_o stable while the corresponding valid is high.
REQ-015 SHALL drop each valid independently in the cycle after its handshake completes (AW and W handshakes may occur in either order or together).
REQ-016 SHALL go to WAIT_B only when both the AW and W handshakes are done.
REQ-017 SHALL have at most one write outstanding at a time.
REQ-018 SHALL assert b_ready_o=1 only in WAIT_B.
REQ-019 SHALL, on b_valid_i=1 in WAIT_B, leave WAIT_B that same cycle.
REQ-020 SHALL, when b_resp_i!=0, set err_o and increment err_cnt_o.
REQ-021 SHALL saturate err_cnt_o at 16'hFFFF (no wrap).
REQ-022 SHALL increment err_cnt_o only once per cycle even when multiple error events coincide.
REQ-023 SHALL hold busy_o=1 in every state except IDLE and DONE.
REQ-024 SHALL hold done_o=1 in DONE until the next start_i.
REQ-025 SHALL, after the last B response, enter DONE and assert done_o in the next cycle.

Reset
REQ-026 SHALL, on arst_ni=0 (immediately, regardless of state, including mid-transaction), drive: state IDLE; all valid outputs, rom_en_o, b_ready_o, busy_o, done_o and err_o =0; err_cnt_o=0; rom_addr_o=0; aw_addr_o and w_data_o =0.
REQ-027 SHALL not issue any AXI valid until start_i is seen after reset release.

Verification
REQ-028 SHALL be verified with these directed scenarios:
- V1: header {B0071DEA,2}, pairs (0x80000000,0x1122334455667788), (0x80000008,0xA5) with always-ready slave and OKAY responses -> 4 writes in order (0x10000600=3200, 0x10000E18=1, then both pairs), done_o=1, err_cnt_o=0.
- V2: header tag 0xDEADBEEF -> no aw_valid_o, done_o=1, err_o=1, err_cnt_o=1.
- V3: N=1, pair address 0x80000004 -> only the 2 config writes, err_cnt_o=1, done_o=1.
- V4: aw_ready_i delayed 3 cycles while w_ready_i=1 immediately -> w_valid_o drops after 1 cycle, aw_valid_o held 4 cycles with a stable address, one B response accepted.
- V5: SLVERR (b_resp_i=2) on the clock-enable write, N=1 -> pair still written, err_cnt_o=1.
- V6: arst_ni pulsed low during SEND -> all outputs 0 asynchronously; start_i after release -> full V1 sequence completes.
